// File: rtl/instr_loader.sv
// instr_loader: receives a little-endian byte stream after a start pulse,
// packs every four bytes into an instruction word and writes it to the
// instruction memory at consecutive word addresses. The core is held in
// reset until the load finishes. A load ends on a NO-OP (all-zero) terminator
// word, which is itself written, or when memory capacity is reached, which
// raises err.
module instr_loader #(
    parameter int WIDTH    = 32,
    parameter int NUM_INST = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             core_hold,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] words_written
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    // Lower three bytes of the word being assembled; the fourth byte goes
    // straight into the write data register when it arrives.
    logic [23:0]      r_word_lo;
    logic [1:0]       r_byte_cnt;
    logic [WIDTH-1:0] r_word_idx;
    logic [WIDTH-1:0] r_words_written;
    logic [WIDTH-1:0] r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_err;

    logic             w_accept;
    logic             w_load_start;
    logic             w_last_byte;
    logic             w_is_term;
    logic             w_at_cap;
    logic [31:0]      w_full_word;

    // Byte address of a word index (index times four).
    function automatic logic [WIDTH-1:0] word_to_byte_addr(input logic [WIDTH-1:0] idx);
        return {idx[WIDTH-3:0], 2'b00};
    endfunction

    // A byte is consumed only while receiving; byte_valid elsewhere is ignored.
    assign w_accept    = byte_valid && (r_state == RECV);
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    assign w_full_word = {byte_data, r_word_lo};

    // Exit decisions in WRITE look at the word just presented on wr_data.
    assign w_is_term = (r_wr_data == '0);
    assign w_at_cap  = (r_word_idx == WIDTH'(NUM_INST - 1));

    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign words_written = r_words_written;
    assign err           = r_err;

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        byte_ready   = 1'b0;
        wr_en        = 1'b0;
        core_hold    = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RECV;
                    w_load_start = 1'b1;
                end
            end
            RECV: begin
                // start is deliberately ignored while a load is in progress
                byte_ready = 1'b1;
                if (w_last_byte) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                if (w_is_term || w_at_cap) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RECV;
                end
            end
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (start) begin
                    w_next_state = RECV;
                    w_load_start = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Byte assembly, write address/data capture and load bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_lo       <= '0;
            r_byte_cnt      <= '0;
            r_word_idx      <= '0;
            r_words_written <= '0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_err           <= 1'b0;
        end else if (w_load_start) begin
            // Counter cleared so any leftover partial bytes get overwritten.
            r_byte_cnt      <= '0;
            r_word_idx      <= '0;
            r_words_written <= '0;
            r_err           <= 1'b0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0: r_word_lo[7:0]   <= byte_data;
                2'd1: r_word_lo[15:8]  <= byte_data;
                2'd2: r_word_lo[23:16] <= byte_data;
                default: begin
                    // Capture on the fourth byte so wr_addr/wr_data are valid
                    // during WRITE and hold afterwards.
                    r_wr_addr <= word_to_byte_addr(r_word_idx);
                    r_wr_data <= WIDTH'(w_full_word);
                end
            endcase
        end else if (r_state == WRITE) begin
            r_words_written <= r_words_written + WIDTH'(1);
            if (w_is_term) begin
                r_err <= 1'b0;
            end else if (w_at_cap) begin
                r_err <= 1'b1;
            end else begin
                r_word_idx <= r_word_idx + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader (NUM_INST=4 so capacity is reachable quickly).
// Expected memory writes are queued as bytes are driven and compared by a
// monitor whenever wr_en is seen.
module tb_instr_loader;

    localparam int WIDTH    = 32;
    localparam int NUM_INST = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             core_hold;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] words_written;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    instr_loader #(.WIDTH(WIDTH), .NUM_INST(NUM_INST)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                logic [31:0] ea;
                logic [31:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (wr_addr !== ea || wr_data !== ed) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", wr_addr, wr_data, ea, ed);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte_ready stayed %b, required 1", byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send_byte(tmp[7:0]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, wr_en, done, err, core_hold} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/wr/done/err/hold=%b, required 00001",
                     {byte_ready, wr_en, done, err, core_hold});
        end
        checks++;
        if (wr_addr !== 32'h0 || wr_data !== 32'h0 || words_written !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h ww=%0d, required 0 0 0", wr_addr, wr_data, words_written);
        end
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b0 || done !== 1'b0 || core_hold !== 1'b1) begin
                errors++;
                $display("FAIL idle_hold: got rdy=%b done=%b hold=%b, required 0 0 1", byte_ready, done, core_hold);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_single_word();
        bit ok;
        pulse_start();
        checks++;
        if (byte_ready !== 1'b1 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL start_recv: got rdy=%b hold=%b, required 1 1", byte_ready, core_hold);
        end
        send_word(32'h0, 32'h0000_0013);
        send_word(32'h4, 32'h0000_0000);
        wait_done(ok);
        checks++;
        if (!ok || err !== 1'b0 || words_written !== 32'd2 || core_hold !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b err=%b ww=%0d hold=%b, required 1 0 2 0",
                     done, err, words_written, core_hold);
        end
    endtask

    task automatic test_gapped();
        bit ok;
        pulse_start();
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'h00A0_8093);
        send_byte(8'h93);
        send_byte(8'h80);
        repeat (5) @(negedge clk);
        send_byte(8'hA0);
        send_byte(8'h00);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 32'h00A0_8093) begin
            errors++;
            $display("FAIL gapped_latency: got wr_en=%b addr=%h data=%h, required 1 0 00a08093", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_data !== 32'h00A0_8093) begin
            errors++;
            $display("FAIL gapped_hold: got wr_en=%b data=%h, required 0 00a08093", wr_en, wr_data);
        end
        send_word(32'h4, 32'h0);
        wait_done(ok);
        checks++;
        if (!ok || err !== 1'b0 || words_written !== 32'd2) begin
            errors++;
            $display("FAIL gapped_done: got done=%b err=%b ww=%0d, required 1 0 2", done, err, words_written);
        end
    endtask

    task automatic test_capacity();
        bit ok;
        pulse_start();
        send_word(32'h0, 32'h1111_1111);
        send_word(32'h4, 32'h2222_2222);
        send_word(32'h8, 32'h3333_3333);
        send_word(32'hC, 32'h4444_4444);
        wait_done(ok);
        checks++;
        if (!ok || err !== 1'b1 || words_written !== 32'd4) begin
            errors++;
            $display("FAIL capacity_done: got done=%b err=%b ww=%0d, required 1 1 4", done, err, words_written);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL capacity_ready: got byte_ready=%b, required 0", byte_ready);
            end
        end
        byte_valid = 1'b0;
        checks++;
        if (words_written !== 32'd4 || done !== 1'b1) begin
            errors++;
            $display("FAIL capacity_extra: got ww=%0d done=%b, required 4 1", words_written, done);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, wr_en, done, err, core_hold} !== 5'b00001) begin
            errors++;
            $display("FAIL async_ctrl: got rdy/wr/done/err/hold=%b, required 00001",
                     {byte_ready, wr_en, done, err, core_hold});
        end
        checks++;
        if (wr_addr !== 32'h0 || wr_data !== 32'h0 || words_written !== 32'h0) begin
            errors++;
            $display("FAIL async_data: got addr=%h data=%h ww=%0d, required 0 0 0", wr_addr, wr_data, words_written);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        pulse_start();
        send_word(32'h0, 32'hDDCC_BBAA);
        send_byte(8'hEE);
        send_byte(8'hFF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (words_written !== 32'h0 || wr_addr !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midword_reset: got ww=%0d addr=%h done=%b, required 0 0 0", words_written, wr_addr, done);
        end
        pulse_start();
        send_word(32'h0, 32'h0403_0201);
        send_word(32'h4, 32'h0);
        wait_done(ok);
        checks++;
        if (!ok || words_written !== 32'd2) begin
            errors++;
            $display("FAIL midword_done: got done=%b ww=%0d, required 1 2", done, words_written);
        end
    endtask

    task automatic test_restart();
        bit ok;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start();
        checks++;
        if (byte_ready !== 1'b1 || words_written !== 32'h0) begin
            errors++;
            $display("FAIL start_in_recv: got rdy=%b ww=%0d, required 1 0", byte_ready, words_written);
        end
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'h0403_0201);
        send_byte(8'h03);
        send_byte(8'h04);
        send_word(32'h4, 32'hCAFE_F00D);
        send_word(32'h8, 32'h0);
        wait_done(ok);
        checks++;
        if (!ok || words_written !== 32'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL restart_first: got done=%b ww=%0d err=%b, required 1 3 0", done, words_written, err);
        end
        pulse_start();
        checks++;
        if (core_hold !== 1'b1 || done !== 1'b0 || words_written !== 32'h0 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: got hold=%b done=%b ww=%0d rdy=%b, required 1 0 0 1",
                     core_hold, done, words_written, byte_ready);
        end
        send_word(32'h0, 32'h1234_5678);
        send_word(32'h4, 32'h0);
        wait_done(ok);
        checks++;
        if (!ok || words_written !== 32'd2) begin
            errors++;
            $display("FAIL restart_second: got done=%b ww=%0d, required 1 2", done, words_written);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gapped();
        test_capacity();
        test_async_reset();
        test_reset_mid_word();
        test_restart();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d outstanding, required 0", exp_addr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the instruction word and address width.
REQ-002 SHALL have parameter NUM_INST, default 32, giving the instruction memory capacity in words.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a program load.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a valid program byte.
REQ-007 SHALL have port byte_data  input  8  program byte stream, little-endian within each word.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte_data this cycle.
REQ-009 SHALL have port wr_en  output  1  single-cycle instruction memory write strobe.
REQ-010 SHALL have port wr_addr  output  WIDTH  byte address of the write (word index times 4).
REQ-011 SHALL have port wr_data  output  WIDTH  assembled instruction word.
REQ-012 SHALL have port core_hold  output  1  holds the core in reset while high.
REQ-013 SHALL have port done  output  1  load complete.
REQ-014 SHALL have port err  output  1  load ended at capacity with no terminator word.
REQ-015 SHALL have port words_written  output  WIDTH  count of words written in the current or last load.

Function
REQ-016 SHALL implement the FSM states IDLE, RECV, WRITE and DONE.
REQ-017 In IDLE, start SHALL cause a transition to RECV and clear the byte counter, word index, words_written and err.
REQ-018 In RECV, byte_ready SHALL be 1; in every other state it SHALL be 0.
REQ-019 A byte SHALL be accepted only on a cycle where byte_valid and byte_ready are both 1.
REQ-020 Byte k (k = 0..3) of a word SHALL land in bits [8k+7:8k] of the assembled word.
REQ-021 The 2-bit byte counter SHALL wrap from 3 to 0 on acceptance of the 4th byte, and the FSM SHALL enter WRITE on the next edge.
REQ-022 In WRITE, for exactly one cycle:
- wr_en SHALL be 1;
- wr_addr SHALL be word_index*4;
- wr_data SHALL be the assembled word;
- words_written SHALL increment on the exit edge.
REQ-023 The latency from accepting the 4th byte to wr_en high SHALL be exactly 1 cycle.
REQ-024 wr_en SHALL be 0 outside WRITE, and wr_addr and wr_data SHALL hold their last values.
REQ-025 Exit from WRITE SHALL follow these rules:
- if the word is 32'h00000000 (NO-OP terminator), go to DONE with err=0;
- else if word_index == NUM_INST-1, go to DONE with err=1;
- else increment word_index and return to RECV.
REQ-026 The terminator word SHALL itself be written to memory.
REQ-027 No write SHALL ever target a word_index >= NUM_INST.
REQ-028 core_hold SHALL be 1 in IDLE, RECV and WRITE, and 0 only in DONE.
REQ-029 done SHALL be 1 only in DONE.
REQ-030 start SHALL be ignored in RECV and WRITE.
REQ-031 start in DONE SHALL restart the load exactly as from IDLE, with core_hold rising the next cycle.
REQ-032 byte_valid outside RECV SHALL be ignored, with no byte consumed.
REQ-033 A partial word, where byte_valid is deasserted mid-word, SHALL be retained indefinitely until the remaining bytes arrive.

Reset
REQ-034 Asserting rst SHALL immediately force the following, regardless of clk:
- state IDLE;
- byte counter, word index, words_written, wr_addr and wr_data all 0;
- wr_en=0, byte_ready=0, done=0, err=0;
- core_hold=1.
REQ-035 Reset asserted mid-load SHALL discard any partial word with no write issued, and the next load SHALL begin at wr_addr 0.
REQ-036 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-037 Reset value check: assert rst asynchronously between edges -> all outputs reach their reset values before the next edge; core_hold=1.
REQ-038 Single-word load: start, then bytes 13,00,00,00 followed by 00,00,00,00 -> first write is wr_addr=0x0 with wr_data=0x00000013, then wr_addr=0x4 with wr_data=0x0; done=1, err=0, words_written=2, core_hold=0.
REQ-039 Gapped stream: bytes 93,80,A0,00 with byte_valid low for 5 cycles between bytes 1 and 2 -> a single write of wr_data=0x00A08093, issued 1 cycle after the 4th byte is accepted.
REQ-040 Capacity with NUM_INST=4: send 4 nonzero words -> 4 writes at addresses 0x0, 0x4, 0x8, 0xC; done=1, err=1; a 5th word's bytes see byte_ready=0.
REQ-041 Reset mid-word: after 2 bytes of word 1, pulse rst, then start and send a full word -> write at wr_addr=0x0 with only the new bytes; no stale data.
REQ-042 Restart and ignored start: start pulsed during RECV has no effect; start in DONE -> core_hold=1, done=0, and the next write goes to wr_addr=0x0.
